// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwards EX/MEM and MEM/WB results into rs1/rs2, selects
// the ALU Y source and buffers instructions in a main register plus one skid entry.
module alu_operand_stage #(
  parameter int DATAWIDTH = 32,
  parameter int REGADDR   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_rs1_data,
  input  logic [DATAWIDTH-1:0] in_rs2_data,
  input  logic [DATAWIDTH-1:0] in_imm,
  input  logic [REGADDR-1:0]   in_rs1_addr,
  input  logic [REGADDR-1:0]   in_rs2_addr,
  input  logic [REGADDR-1:0]   in_rd_addr,
  input  logic                 in_alusrc,
  input  logic [2:0]           in_aluop,
  input  logic                 in_regwrite,
  input  logic                 flush,
  input  logic                 fwd_ex_valid,
  input  logic [REGADDR-1:0]   fwd_ex_rd,
  input  logic [DATAWIDTH-1:0] fwd_ex_data,
  input  logic                 fwd_wb_valid,
  input  logic [REGADDR-1:0]   fwd_wb_rd,
  input  logic [DATAWIDTH-1:0] fwd_wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] X,
  output logic [DATAWIDTH-1:0] Y,
  output logic [2:0]           ALUop,
  output logic [DATAWIDTH-1:0] out_store_data,
  output logic [REGADDR-1:0]   out_rd_addr,
  output logic                 out_regwrite
);

  typedef struct packed {
    logic [DATAWIDTH-1:0] x;
    logic [DATAWIDTH-1:0] y;
    logic [DATAWIDTH-1:0] store;
    logic [2:0]           op;
    logic [REGADDR-1:0]   rd;
    logic                 regwrite;
  } entry_t;

  entry_t main_q, skid_q, incoming;
  logic   skid_valid;
  logic   accept, transfer;
  logic   main_valid_d, skid_valid_d;
  logic   load_main, main_from_skid, load_skid;
  logic [DATAWIDTH-1:0] rs1_fwd, rs2_fwd;

  // EX/MEM wins over MEM/WB; register x0 is hard-wired and never forwarded.
  function automatic logic [DATAWIDTH-1:0] fwd_sel(
    input logic [REGADDR-1:0]   rs,
    input logic [DATAWIDTH-1:0] rf_data,
    input logic                 ex_valid,
    input logic [REGADDR-1:0]   ex_rd,
    input logic [DATAWIDTH-1:0] ex_data,
    input logic                 wb_valid,
    input logic [REGADDR-1:0]   wb_rd,
    input logic [DATAWIDTH-1:0] wb_data
  );
    if (rs != '0 && ex_valid && ex_rd == rs)      return ex_data;
    else if (rs != '0 && wb_valid && wb_rd == rs) return wb_data;
    else                                          return rf_data;
  endfunction

  assign rs1_fwd = fwd_sel(in_rs1_addr, in_rs1_data, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                           fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  assign rs2_fwd = fwd_sel(in_rs2_addr, in_rs2_data, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                           fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

  assign incoming.x        = rs1_fwd;
  assign incoming.y        = in_alusrc ? in_imm : rs2_fwd;
  assign incoming.store    = rs2_fwd;
  assign incoming.op       = in_aluop;
  assign incoming.rd       = in_rd_addr;
  assign incoming.regwrite = in_regwrite;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    main_valid_d   = out_valid;
    skid_valid_d   = skid_valid;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid) begin
      if (transfer) begin
        load_main      = 1'b1;
        main_from_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end
    end else if (!out_valid || transfer) begin
      main_valid_d = accept;
      load_main    = accept;
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
    end else begin
      out_valid  <= main_valid_d;
      skid_valid <= skid_valid_d;
      if (load_main) main_q <= main_from_skid ? skid_q : incoming;
    end
  end

  // NOTE: skid payload is not reset; it is only ever read while skid_valid is set.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= incoming;
  end

  assign X              = main_q.x;
  assign Y              = main_q.y;
  assign ALUop          = main_q.op;
  assign out_store_data = main_q.store;
  assign out_rd_addr    = main_q.rd;
  assign out_regwrite   = main_q.regwrite;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios then random traffic,
// compared against a queue-based reference of the stage's FIFO behaviour.
module tb_alu_operand_stage;
  localparam int DW = 32;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic [RA-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic          in_alusrc, in_regwrite, flush;
  logic [2:0]    in_aluop;
  logic          fwd_ex_valid, fwd_wb_valid;
  logic [RA-1:0] fwd_ex_rd, fwd_wb_rd;
  logic [DW-1:0] fwd_ex_data, fwd_wb_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] X, Y, out_store_data;
  logic [2:0]    ALUop;
  logic [RA-1:0] out_rd_addr;
  logic          out_regwrite;

  alu_operand_stage #(.DATAWIDTH(DW), .REGADDR(RA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alusrc(in_alusrc), .in_aluop(in_aluop), .in_regwrite(in_regwrite), .flush(flush),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .X(X), .Y(Y), .ALUop(ALUop),
    .out_store_data(out_store_data), .out_rd_addr(out_rd_addr), .out_regwrite(out_regwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] x, y, st;
    logic [2:0]    op;
    logic [RA-1:0] rd;
    logic          rw;
  } exp_t;

  exp_t          mq[$];
  logic [DW-1:0] got[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            last_acc;
  bit            track = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_operand(input logic [RA-1:0] a, input logic [DW-1:0] rf);
    if (a == 0) return rf;
    if (fwd_ex_valid && fwd_ex_rd == a) return fwd_ex_data;
    if (fwd_wb_valid && fwd_wb_rd == a) return fwd_wb_data;
    return rf;
  endfunction

  task automatic check_outputs();
    check("in_ready", in_ready, mq.size() < 2);
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("X", X, mq[0].x);
      check("Y", Y, mq[0].y);
      check("store_data", out_store_data, mq[0].st);
      check("ALUop", ALUop, mq[0].op);
      check("rd_addr", out_rd_addr, mq[0].rd);
      check("regwrite", out_regwrite, mq[0].rw);
    end
  endtask

  // One clock: predict the transaction, step the clock, update the model, check at negedge.
  task automatic cycle();
    exp_t e;
    bit   acc, xfer, fl;
    acc  = in_valid && (mq.size() < 2);
    xfer = (mq.size() != 0) && out_ready;
    fl   = flush;
    e.x  = ref_operand(in_rs1_addr, in_rs1_data);
    e.st = ref_operand(in_rs2_addr, in_rs2_data);
    e.y  = in_alusrc ? in_imm : e.st;
    e.op = in_aluop;
    e.rd = in_rd_addr;
    e.rw = in_regwrite;
    if (track && out_valid && out_ready) got.push_back(X);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (xfer) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    last_acc = acc && !fl;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_instr(input logic [RA-1:0] rs1a, input logic [RA-1:0] rs2a,
                           input logic [RA-1:0] rda, input logic [DW-1:0] rs1d,
                           input logic [DW-1:0] rs2d, input logic [DW-1:0] imm,
                           input logic alusrc, input logic [2:0] op);
    in_valid    = 1'b1;
    in_rs1_addr = rs1a;  in_rs2_addr = rs2a;  in_rd_addr = rda;
    in_rs1_data = rs1d;  in_rs2_data = rs2d;  in_imm     = imm;
    in_alusrc   = alusrc; in_aluop   = op;    in_regwrite = 1'b1;
  endtask

  task automatic clear_fwd();
    fwd_ex_valid = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
    fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_instr('0, '0, '0, '0, '0, '0, 1'b0, 3'b000);
    in_valid = 1'b0; in_regwrite = 1'b0;
    clear_fwd();

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_X", X, 0);
    check("rst_Y", Y, 0);
    check("rst_store", out_store_data, 0);
    check("rst_ALUop", ALUop, 0);
    check("rst_rd", out_rd_addr, 0);
    check("rst_regwrite", out_regwrite, 0);
    rst_n = 1'b1;
    cycle();

    // Single instruction, immediate operand
    out_ready = 1'b1;
    set_instr(5'd1, 5'd2, 5'd4, 32'd5, 32'd9, 32'd7, 1'b1, 3'b000);
    cycle();
    check("single_valid", out_valid, 1);
    check("single_X", X, 5);
    check("single_Y", Y, 7);
    check("single_op", ALUop, 0);
    in_valid = 1'b0;
    cycle();
    check("single_drain", out_valid, 0);

    // Forward priority: EX over WB, then WB alone
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd3; fwd_ex_data = 32'hAAAA;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'hBBBB;
    set_instr(5'd3, 5'd3, 5'd6, 32'd1, 32'd2, 32'h55, 1'b0, 3'b101);
    cycle();
    check("fwd_ex_X", X, 32'hAAAA);
    check("fwd_ex_Y", Y, 32'hAAAA);
    check("fwd_ex_st", out_store_data, 32'hAAAA);
    fwd_ex_valid = 1'b0;
    cycle();
    check("fwd_wb_X", X, 32'hBBBB);
    check("fwd_wb_Y", Y, 32'hBBBB);
    check("fwd_wb_st", out_store_data, 32'hBBBB);

    // x0 is never forwarded
    clear_fwd();
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd0; fwd_ex_data = 32'hFFFF_FFFF;
    set_instr(5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd3, 1'b1, 3'b010);
    cycle();
    check("x0_X", X, 0);
    clear_fwd();
    in_valid = 1'b0;
    cycle();

    // Backpressure: 4 tagged instructions, out_ready low for 3 cycles
    track = 1'b1; got.delete();
    out_ready = 1'b0;
    set_instr(5'd0, 5'd0, 5'd1, 32'd1, 32'd0, 32'd0, 1'b1, 3'b001);
    cycle();
    set_instr(5'd0, 5'd0, 5'd2, 32'd2, 32'd0, 32'd0, 1'b1, 3'b001);
    cycle();
    check("bp_in_ready_drop", in_ready, 0);
    set_instr(5'd0, 5'd0, 5'd3, 32'd3, 32'd0, 32'd0, 1'b1, 3'b001);
    cycle();
    check("bp_stable_X", X, 1);
    check("bp_stable_rd", out_rd_addr, 1);
    out_ready = 1'b1;
    for (int t = 3; t <= 4; t++) begin
      set_instr(5'd0, 5'd0, RA'(t), DW'(t), 32'd0, 32'd0, 1'b1, 3'b001);
      for (int k = 0; k < 5; k++) begin
        cycle();
        if (last_acc) break;
      end
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    track = 1'b0;
    check("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", got[i], i + 1);

    // Flush while FULL with an input presented
    out_ready = 1'b0;
    set_instr(5'd0, 5'd0, 5'd10, 32'h10, 32'd0, 32'd0, 1'b1, 3'b011);
    cycle();
    set_instr(5'd0, 5'd0, 5'd11, 32'h11, 32'd0, 32'd0, 1'b1, 3'b011);
    cycle();
    set_instr(5'd0, 5'd0, 5'd12, 32'h77, 32'd0, 32'd0, 1'b1, 3'b011);
    flush = 1'b1;
    cycle();
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cycle();

    // Flush in ONE state with a same-cycle accept that must be discarded
    out_ready = 1'b0;
    set_instr(5'd0, 5'd0, 5'd13, 32'h13, 32'd0, 32'd0, 1'b1, 3'b100);
    cycle();
    set_instr(5'd0, 5'd0, 5'd14, 32'h78, 32'd0, 32'd0, 1'b1, 3'b100);
    flush = 1'b1;
    cycle();
    check("flush1_out_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cycle();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    set_instr(5'd0, 5'd0, 5'd15, 32'h21, 32'd0, 32'd9, 1'b0, 3'b110);
    cycle();
    set_instr(5'd0, 5'd0, 5'd16, 32'h22, 32'd0, 32'd9, 1'b0, 3'b110);
    cycle();
    check("pre_rst_full", in_ready, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_X", X, 0);
    check("arst_Y", Y, 0);
    mq.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_outputs();
    check("arst_in_ready", in_ready, 1);

    // Random traffic with frequent hazards on a small register window
    for (int n = 0; n < 400; n++) begin
      set_instr(RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)), RA'($urandom_range(0, 31)),
                $urandom, $urandom, $urandom, 1'($urandom), 3'($urandom));
      in_valid     = ($urandom_range(0, 3) != 0);
      in_regwrite  = 1'($urandom);
      out_ready    = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 31) == 0);
      fwd_ex_valid = 1'($urandom); fwd_ex_rd = RA'($urandom_range(0, 3)); fwd_ex_data = $urandom;
      fwd_wb_valid = 1'($urandom); fwd_wb_rd = RA'($urandom_range(0, 3)); fwd_wb_data = $urandom;
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check("final_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU.
- Accepts decoded instructions from the decode stage and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Selects the second operand (register or immediate) and presents registered X, Y and ALUop to the ALU.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so in_ready is a registered signal.

Parameters:
DATAWIDTH, 32, operand/result width
REGADDR, 5, register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode stage presents an instruction
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_rs1_data  in  DATAWIDTH  register-file read value of rs1
in_rs2_data  in  DATAWIDTH  register-file read value of rs2
in_imm  in  DATAWIDTH  sign-extended immediate
in_rs1_addr  in  REGADDR  rs1 index
in_rs2_addr  in  REGADDR  rs2 index
in_rd_addr  in  REGADDR  destination index
in_alusrc  in  1  1: Y=imm, 0: Y=rs2 operand
in_aluop  in  3  {M0,S1,S0} from ALU decode
in_regwrite  in  1  instruction writes rd
flush  in  1  synchronous kill of all held and incoming entries
fwd_ex_valid  in  1  EX/MEM holds a register-writing result
fwd_ex_rd  in  REGADDR  EX/MEM destination
fwd_ex_data  in  DATAWIDTH  EX/MEM result
fwd_wb_valid  in  1  MEM/WB holds a register-writing result
fwd_wb_rd  in  REGADDR  MEM/WB destination
fwd_wb_data  in  DATAWIDTH  MEM/WB result
out_valid  out  1  X/Y/ALUop are valid
out_ready  in  1  ALU/EX side consumes this cycle
X  out  DATAWIDTH  ALU source X
Y  out  DATAWIDTH  ALU source Y
ALUop  out  3  ALU function select
out_store_data  out  DATAWIDTH  forwarded rs2 value, independent of alusrc
out_rd_addr  out  REGADDR  destination passthrough
out_regwrite  out  1  regwrite passthrough

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, skid_valid=0, in_ready=1.
  - X=Y=out_store_data=0, ALUop=0, out_rd_addr=0, out_regwrite=0.
  - Takes effect mid-transfer: any held entry is lost.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_* payload is held stable while out_valid & !out_ready.
- Forwarding, combinational at the input, applied per source rs1 and rs2:
  - If fwd_ex_valid & fwd_ex_rd==rs & rs!=0, use fwd_ex_data.
  - Else if fwd_wb_valid & fwd_wb_rd==rs & rs!=0, use fwd_wb_data.
  - Else use the register-file value.
  - EX has priority over WB.
  - Index 0 is never forwarded.
  - Forwarding is evaluated only at acceptance. Held entries are not re-forwarded; the hazard unit guarantees producers stall while this stage is blocked.
- Operand formation at acceptance:
  - X = fwd(rs1).
  - Y = in_alusrc ? in_imm : fwd(rs2).
  - store_data = fwd(rs2).
- Storage states (main_valid=out_valid, skid_valid):
  - EMPTY (0,0): accept loads main; out_valid next cycle. Latency 1 cycle.
  - ONE (1,0):
    - accept & transfer: main reloads.
    - accept & !transfer: entry goes to skid, in_ready drops next cycle.
    - transfer only: EMPTY.
  - FULL (1,1), in_ready=0:
    - transfer: skid moves to main, ONE.
    - otherwise: hold.
- Throughput is 1 instruction/cycle when out_ready is held high.
- Ordering is strictly FIFO; no entry is ever dropped or duplicated except by flush or reset.
- flush (priority over all other events in the cycle):
  - Next state EMPTY, in_ready=1.
  - An input accepted in the same cycle is discarded.
  - A same-cycle output transfer still counts as consumed downstream.
  - Payload registers need not clear.

Test Plan:
- Single instruction:
  - Stimulus: rs1_data=5, imm=7, alusrc=1, aluop=3'b000, out_ready=1.
  - Required: out_valid one cycle after accept, X=5, Y=7, ALUop=0, then out_valid=0.
- Forward priority:
  - Stimulus: rs1=rs2=3, fwd_ex (rd 3, 0xAAAA), fwd_wb (rd 3, 0xBBBB), alusrc=0.
  - Required: X=Y=store_data=0xAAAA.
  - Repeat with fwd_ex_valid=0: required 0xBBBB.
- x0 protection:
  - Stimulus: rs1=0, rs1_data=0, fwd_ex (rd 0, 0xFFFF_FFFF).
  - Required: X=0.
- Backpressure:
  - Stimulus: stream of 4 instructions (tags 1..4) with out_ready=0 for 3 cycles.
  - Required: in_ready drops after 2 accepts, payload stable while blocked.
  - After release: tags emerge 1,2,3,4 in order, no loss.
- Flush:
  - Stimulus: fill to FULL, assert flush with in_valid=1.
  - Required: next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- Async reset mid-stream:
  - Stimulus: drop rst_n between clock edges while FULL.
  - Required: out_valid=0 and X=Y=0 immediately; in_ready=1 after release.
